// File: rtl/iwrr_pkg.sv
// Shared definitions for the IWRR credit tracker: FSM state encoding and
// default sizing for requesters, weights and the round counter.
package iwrr_pkg;

    localparam int DEF_REQUESTER_NUM = 3;
    localparam int DEF_WEIGHT_W      = 2;
    localparam int DEF_ROUND_CNT_W   = 8;

    typedef enum logic [1:0] {
        S_UNCFG  = 2'd0,
        S_RUN    = 2'd1,
        S_RELOAD = 2'd2
    } state_t;

endpackage

// File: rtl/iwrr_credit_tracker_if.sv
// Arbiter <-> credit tracker bundle. The master is the arbiter/config side,
// the slave is the credit tracker.
interface iwrr_credit_tracker_if
    import iwrr_pkg::*;
#(
    parameter int P_REQUESTER_NUM = DEF_REQUESTER_NUM,
    parameter int P_WEIGHT_W      = DEF_WEIGHT_W,
    parameter int P_ROUND_CNT_W   = DEF_ROUND_CNT_W
) ();

    logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_weight_i;
    logic                                  weight_load_i;
    logic [P_REQUESTER_NUM-1:0]            req_i;
    logic [P_REQUESTER_NUM-1:0]            grant_i;
    logic                                  round_comp_i;
    logic [P_REQUESTER_NUM-1:0]            eligible_o;
    logic [P_REQUESTER_NUM-1:0]            req_weight_remain_o;
    logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] credit_o;
    logic                                  cfg_valid_o;
    logic [P_ROUND_CNT_W-1:0]              round_cnt_o;
    logic                                  grant_err_o;

    modport master (
        output req_weight_i, weight_load_i, req_i, grant_i, round_comp_i,
        input  eligible_o, req_weight_remain_o, credit_o, cfg_valid_o,
               round_cnt_o, grant_err_o
    );

    modport slave (
        input  req_weight_i, weight_load_i, req_i, grant_i, round_comp_i,
        output eligible_o, req_weight_remain_o, credit_o, cfg_valid_o,
               round_cnt_o, grant_err_o
    );

endinterface

// File: rtl/iwrr_credit_cnt.sv
// One requester's credit down-counter: load has priority over decrement,
// and the decrement saturates at zero.
module iwrr_credit_cnt #(
    parameter int P_WEIGHT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [P_WEIGHT_W-1:0] load_val,
    input  logic                  dec,
    output logic [P_WEIGHT_W-1:0] cnt,
    output logic                  zero,
    output logic                  gt1
);

    localparam logic [P_WEIGHT_W-1:0] ONE = P_WEIGHT_W'(1);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);
    assign gt1  = (cnt > ONE);

endmodule

// File: rtl/iwrr_credit_tracker.sv
// IWRR per-requester credit bank with active/shadow weights and round reload.
// Optional IWRR_CREDIT_AUTO_RELOAD_EN: reload when all requesters are exhausted.
module iwrr_credit_tracker
    import iwrr_pkg::*;
#(
    parameter int P_REQUESTER_NUM = DEF_REQUESTER_NUM,
    parameter int P_WEIGHT_W      = DEF_WEIGHT_W,
    parameter int P_ROUND_CNT_W   = DEF_ROUND_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    iwrr_credit_tracker_if.slave bus
);

    localparam int N = P_REQUESTER_NUM;
    localparam int W = P_WEIGHT_W;

    state_t               state, state_nxt;
    logic [0:N*W-1]       active_w, shadow_w, reload_w, load_w;
    logic                 pending;
    logic [P_ROUND_CNT_W-1:0] round_cnt;
    logic                 grant_err;
    logic                 cnt_load;
    logic [W-1:0]         cnt      [N];
    logic                 cnt_zero [N];
    logic                 cnt_gt1  [N];
    logic [N-1:0]         has_credit, dec;
    logic                 onehot0, auto_reload, boundary, grant_bad;

    for (genvar n = 0; n < N; n++) begin : g_cnt
        iwrr_credit_cnt #(.P_WEIGHT_W(W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (cnt_load),
            .load_val (load_w[(n+1)*W-1 -: W]),
            .dec      (dec[n]),
            .cnt      (cnt[n]),
            .zero     (cnt_zero[n]),
            .gt1      (cnt_gt1[n])
        );
    end

    // A pending shadow update takes effect in the same reload that copies it.
    assign reload_w = pending ? shadow_w : active_w;

    always_comb begin
        for (int n = 0; n < N; n++) has_credit[n] = !cnt_zero[n];
        onehot0 = ((bus.grant_i & (bus.grant_i - N'(1))) == '0);
        dec     = (state == S_RUN && onehot0) ? (bus.grant_i & has_credit) : '0;
`ifdef IWRR_CREDIT_AUTO_RELOAD_EN
        auto_reload = (bus.req_i != '0) && ((bus.req_i & has_credit) == '0);
`else
        auto_reload = 1'b0;
`endif
        boundary  = bus.round_comp_i || auto_reload;
        grant_bad = (bus.grant_i != '0) && (state != S_RELOAD) &&
                    (!onehot0 || ((bus.grant_i & ~has_credit) != '0) || state == S_UNCFG);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        load_w    = reload_w;
        case (state)
            S_UNCFG: begin
                if (bus.weight_load_i) begin
                    state_nxt = S_RUN;
                    cnt_load  = 1'b1;
                    load_w    = bus.req_weight_i;
                end
            end
            S_RUN: begin
                if (boundary) state_nxt = S_RELOAD;
            end
            S_RELOAD: begin
                cnt_load  = 1'b1;
                state_nxt = S_RUN;
            end
            default: state_nxt = S_UNCFG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_UNCFG;
            active_w  <= '0;
            shadow_w  <= '0;
            pending   <= 1'b0;
            round_cnt <= '0;
            grant_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_bad) grant_err <= 1'b1;
            if (state == S_UNCFG && bus.weight_load_i) begin
                active_w <= bus.req_weight_i;
                shadow_w <= bus.req_weight_i;
            end
            if (state == S_RELOAD) begin
                if (pending) active_w <= shadow_w;
                pending   <= 1'b0;
                round_cnt <= round_cnt + P_ROUND_CNT_W'(1);
            end
            // A load arriving during the reload cycle is kept for the next round.
            if (state != S_UNCFG && bus.weight_load_i) begin
                shadow_w <= bus.req_weight_i;
                pending  <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.credit_o = '0;
        for (int n = 0; n < N; n++) begin
            bus.credit_o[(n+1)*W-1 -: W]   = cnt[n];
            bus.eligible_o[n]          = bus.req_i[n] && has_credit[n] && (state != S_RELOAD);
            bus.req_weight_remain_o[n] = cnt_gt1[n];
        end
    end

    assign bus.cfg_valid_o = (state != S_UNCFG);
    assign bus.round_cnt_o = round_cnt;
    assign bus.grant_err_o = grant_err;

endmodule
